llc_line_fill_arbiter: RTL and testbench

- Shares one AXI read channel between the L1-I and L1-D line-fill requesters.
- Round-robin grant; issues one 8-beat WRAP burst per request; assembles 64-bit beats into a 512-bit line; returns the line to the winner with a one-cycle valid pulse.
- Sits between the L1 caches and the LLC's AXI master read port.
- Write, AW/W/B and snoop paths are out of scope.

---
 rtl/llc_arb_pkg.sv | 10 +
 rtl/llc_line_fill_arbiter_line_assembler.sv | 32 +++
 rtl/llc_line_fill_arbiter.sv | 111 +++++++++++
 tb/tb_llc_line_fill_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/llc_arb_pkg.sv
// llc_arb_pkg: shared FSM/requester types and AXI read-burst constants for llc_line_fill_arbiter
package llc_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  typedef enum logic {REQ_I, REQ_D} req_t;
  localparam int BEATS = 8;
  localparam int WORD_W = $clog2(BEATS);
  localparam logic [7:0] ARLEN = 8'(BEATS - 1);
  localparam logic [2:0] ARSIZE_8B = 3'b011;
  localparam logic [1:0] ARBURST_WRAP = 2'b10;
endpackage

// File: rtl/llc_line_fill_arbiter_line_assembler.sv
// line_assembler: counts beats of a WRAP burst and writes each into line word (start_word + beat) mod BEATS
module line_assembler
  import llc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BITS = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic [WORD_W-1:0] start_word,
  input  logic beat,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [WORD_W-1:0] count,
  output logic [LINE_BITS-1:0] line
);
  logic [WORD_W-1:0] start, idx;
  assign idx = start + count;
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      start <= '0;
      line <= '0;
    end else begin
      if (load) begin
        count <= '0;
        start <= start_word;
      end else if (beat) count <= count + 1'b1;
      if (beat) line[idx*DATA_WIDTH +: DATA_WIDTH] <= data;
    end
  end
endmodule

// File: rtl/llc_line_fill_arbiter.sv
// llc_line_fill_arbiter: round-robin L1-I/L1-D line fills over one AXI read port; LLC_ARB_PERF_CNT_EN adds perf counters
module llc_line_fill_arbiter
  import llc_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BITS = 512,
  parameter int ID_WIDTH = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic i_req_valid,
  output logic [LINE_BITS-1:0] i_rsp_data,
  output logic i_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic d_req_valid,
  output logic [LINE_BITS-1:0] d_rsp_data,
  output logic d_rsp_valid,
  output logic [ID_WIDTH-1:0] m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0] m_axi_arlen,
  output logic [2:0] m_axi_arsize,
  output logic [1:0] m_axi_arburst,
  output logic m_axi_arvalid,
  input  logic m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0] m_axi_rresp,
  input  logic m_axi_rlast,
  input  logic m_axi_rvalid,
  output logic m_axi_rready,
  output logic err
`ifdef LLC_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_i_fills,
  output logic [31:0] perf_d_fills,
  output logic [31:0] perf_wait_cycles
`endif
);
  state_t state, state_nxt;
  req_t winner, last_grant, grant;
  logic [ADDR_WIDTH-1:0] addr, grant_addr;
  logic [LINE_BITS-1:0] line, i_line, d_line;
  logic [WORD_W-1:0] count;
  logic any_req, start, beat, last_beat;
  assign any_req = i_req_valid | d_req_valid;
  assign grant = (i_req_valid && (!d_req_valid || last_grant == REQ_D)) ? REQ_I : REQ_D;
  assign grant_addr = grant == REQ_I ? i_req_addr : d_req_addr;
  assign start = state == IDLE && any_req;
  assign beat = state == DATA && m_axi_rvalid;
  assign last_beat = beat && count == WORD_W'(BEATS - 1);
  assign m_axi_arid = ID_WIDTH'(winner);
  assign m_axi_araddr = addr & ~ADDR_WIDTH'(7);
  assign m_axi_arlen = ARLEN;
  assign m_axi_arsize = ARSIZE_8B;
  assign m_axi_arburst = ARBURST_WRAP;
  line_assembler #(.DATA_WIDTH(DATA_WIDTH), .LINE_BITS(LINE_BITS)) u_asm (
    .clk(clk), .reset(reset), .load(start), .start_word(grant_addr[3 +: WORD_W]),
    .beat(beat), .data(m_axi_rdata), .count(count), .line(line)
  );
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (any_req ? ADDR : IDLE) :
                state == ADDR ? (m_axi_arready ? DATA : ADDR) :
                state == DATA ? (last_beat ? RESP : DATA) : IDLE;
  // The fresh line is forwarded during RESP; afterwards the per-requester copy holds it.
  always_comb begin
    m_axi_arvalid = state == ADDR;
    m_axi_rready = state == DATA;
    i_rsp_valid = state == RESP && winner == REQ_I;
    d_rsp_valid = state == RESP && winner == REQ_D;
    i_rsp_data = i_rsp_valid ? line : i_line;
    d_rsp_data = d_rsp_valid ? line : d_line;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      winner <= REQ_I;
      last_grant <= REQ_D;
      addr <= '0;
      i_line <= '0;
      d_line <= '0;
      err <= 1'b0;
    end else begin
      if (start) begin
        winner <= grant;
        addr <= grant_addr;
      end
      if (state == RESP) last_grant <= winner;
      if (i_rsp_valid) i_line <= line;
      if (d_rsp_valid) d_line <= line;
      if (beat && (m_axi_rresp != 2'b00 || m_axi_rlast != (count == WORD_W'(BEATS - 1)))) err <= 1'b1;
    end
  end
`ifdef LLC_ARB_PERF_CNT_EN
  req_t served;
  logic waiting;
  assign served = state == IDLE ? grant : winner;
  assign waiting = (i_req_valid && served != REQ_I) || (d_req_valid && served != REQ_D);
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_i_fills <= '0;
      perf_d_fills <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (i_rsp_valid && !(&perf_i_fills)) perf_i_fills <= perf_i_fills + 1'b1;
      if (d_rsp_valid && !(&perf_d_fills)) perf_d_fills <= perf_d_fills + 1'b1;
      if (waiting && !(&perf_wait_cycles)) perf_wait_cycles <= perf_wait_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_llc_line_fill_arbiter.sv
// tb_llc_line_fill_arbiter: directed and randomized fills checked against a round-robin/wrap-burst reference model
module tb_llc_line_fill_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic [63:0] i_req_addr = '0, d_req_addr = '0, m_axi_rdata = '0, m_axi_araddr;
  logic i_req_valid = 1'b0, d_req_valid = 1'b0, i_rsp_valid, d_rsp_valid;
  logic [511:0] i_rsp_data, d_rsp_data;
  logic [12:0] m_axi_arid;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst, m_axi_rresp = '0;
  logic m_axi_arvalid, m_axi_arready = 1'b0, m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready, err;
  int checks = 0, errors = 0;
  bit last_g, exp_err;
  logic [511:0] exp_i, exp_d;

  llc_line_fill_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_rsp_data(i_rsp_data), .i_rsp_valid(i_rsp_valid),
    .d_req_addr(d_req_addr), .d_req_valid(d_req_valid), .d_rsp_data(d_rsp_data), .d_rsp_valid(d_rsp_valid),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_arready = 1'b0;
    step;
    step;
    chk("reset_ctrl", {m_axi_arvalid, m_axi_rready, i_rsp_valid, d_rsp_valid, err}, 5'b0);
    chk("reset_i_data", i_rsp_data, '0);
    chk("reset_d_data", d_rsp_data, '0);
    reset = 1'b1;
    last_g = 1'b1;
    exp_err = 1'b0;
    exp_i = '0;
    exp_d = '0;
  endtask

  // One full fill as seen by the AXI slave and the model; abort_at >= 0 resets after that beat.
  task automatic serve(input int ar_dly, input int gap_min, input int gap_max,
                       input int bad_resp, input int early_last, input int abort_at, input longint base);
    bit w;
    logic [63:0] a, dat;
    logic [511:0] line;
    int sw, n;
    line = '0;
    w = (i_req_valid && d_req_valid) ? !last_g : d_req_valid;
    a = w ? d_req_addr : i_req_addr;
    sw = int'((a / 8) % 8);
    n = 0;
    do begin
      step;
      n++;
    end while (!m_axi_arvalid && n < 20);
    chk("arvalid", m_axi_arvalid, 1'b1);
    chk("arid", m_axi_arid, 13'(w));
    chk("ar_fixed", {m_axi_arlen, m_axi_arsize, m_axi_arburst}, {8'd7, 3'b011, 2'b10});
    repeat (ar_dly) begin
      chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, (a / 8) * 8});
      step;
    end
    chk("araddr", m_axi_araddr, (a / 8) * 8);
    m_axi_arready = 1'b1;
    step;
    m_axi_arready = 1'b0;
    chk("rready", m_axi_rready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      m_axi_rvalid = 1'b0;
      repeat ($urandom_range(gap_max, gap_min)) step;
      chk("rsp_early", {i_rsp_valid, d_rsp_valid}, 2'b00);
      dat = base < 0 ? {$urandom, $urandom} : 64'(base + k);
      line[((sw + k) % 8) * 64 +: 64] = dat;
      m_axi_rvalid = 1'b1;
      m_axi_rdata = dat;
      m_axi_rresp = k == bad_resp ? 2'b10 : 2'b00;
      m_axi_rlast = k == 7 || k == early_last;
      if (k == bad_resp || k == early_last) exp_err = 1'b1;
      step;
      if (k == abort_at) begin
        do_reset;
        return;
      end
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
    chk("rsp_valid", {i_rsp_valid, d_rsp_valid}, w ? 2'b01 : 2'b10);
    chk("rsp_data", w ? d_rsp_data : i_rsp_data, line);
    chk("err", err, exp_err);
    if (w) begin
      exp_d = line;
      d_req_valid = 1'b0;
    end else begin
      exp_i = line;
      i_req_valid = 1'b0;
    end
    last_g = w;
    step;
    chk("rsp_pulse", {i_rsp_valid, d_rsp_valid}, 2'b00);
    chk("i_hold", i_rsp_data, exp_i);
    chk("d_hold", d_rsp_data, exp_d);
  endtask

  initial begin
    do_reset;
    i_req_addr = 64'h1000;
    i_req_valid = 1'b1;
    serve(0, 0, 0, -1, -1, -1, 0);
    d_req_addr = 64'h2038;
    d_req_valid = 1'b1;
    serve(0, 0, 0, -1, -1, -1, 64'hA0);
    do_reset;
    for (int p = 0; p < 2; p++) begin
      i_req_addr = {$urandom, $urandom};
      d_req_addr = {$urandom, $urandom};
      i_req_valid = 1'b1;
      d_req_valid = 1'b1;
      serve(0, 0, 1, -1, -1, -1, -1);
      chk("tie_first_i", last_g, 1'b0);
      serve(0, 0, 1, -1, -1, -1, -1);
      chk("tie_then_d", last_g, 1'b1);
    end
    i_req_addr = 64'h3010;
    i_req_valid = 1'b1;
    serve(5, 3, 3, -1, -1, -1, -1);
    d_req_addr = 64'h4020;
    d_req_valid = 1'b1;
    serve(1, 0, 1, 3, -1, -1, -1);
    i_req_addr = 64'h5008;
    i_req_valid = 1'b1;
    serve(0, 0, 0, -1, -1, -1, -1);
    do_reset;
    i_req_addr = 64'h6028;
    i_req_valid = 1'b1;
    serve(0, 0, 1, -1, 5, -1, -1);
    d_req_addr = 64'h7030;
    d_req_valid = 1'b1;
    serve(0, 0, 1, -1, -1, 4, -1);
    d_req_addr = 64'h7118;
    d_req_valid = 1'b1;
    serve(2, 0, 2, -1, -1, -1, -1);
    for (int it = 0; it < 40; it++) begin
      if (!i_req_valid && $urandom_range(1, 0) == 1) begin
        i_req_addr = {$urandom, $urandom};
        i_req_valid = 1'b1;
      end
      if (!d_req_valid && ($urandom_range(1, 0) == 1 || !i_req_valid)) begin
        d_req_addr = {$urandom, $urandom};
        d_req_valid = 1'b1;
      end
      serve($urandom_range(3, 0), 0, 2, $urandom_range(15, 0) == 0 ? $urandom_range(7, 0) : -1, -1, -1, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
